// File: rtl/fp32_divider_seq.sv
// Iterative IEEE-754 single-precision divider (res = a / b).
// Restoring division, one quotient bit per clock, one operation in flight.
// Truncating (no rounding); zero divisor and zero dividend short-circuit to DONE.
module fp32_divider_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EXP_W+MANT_W:0]       a,
    input  logic [EXP_W+MANT_W:0]       b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+MANT_W:0]       res,
    output logic                        dz
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int MW = MANT_W + 1;           // mantissa with hidden one
    localparam int QW = MANT_W + 2;           // quotient / remainder width
    localparam int CW = $clog2(QW);
    localparam int EW = EXP_W + 2;            // signed working exponent
    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S = '0;

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [MW-1:0]           mb_q, mb_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic [QW-1:0]           rem_q, rem_d;
    logic [QW-1:0]           q_q, q_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [W-1:0]            res_q, res_d;
    logic                    dz_q, dz_d;

    logic                    sign_in;
    logic                    a_zero, b_zero;
    logic signed [EW-1:0]    e_in;
    logic [QW-1:0]           diff;
    logic signed [EW-1:0]    en;
    logic [MANT_W-1:0]       mant;

    assign sign_in = a[W-1] ^ b[W-1];
    assign a_zero  = (a[W-2:0] == '0);
    assign b_zero  = (b[W-2:0] == '0);
    assign e_in    = $signed({2'b00, a[W-2:MANT_W]}) - $signed({2'b00, b[W-2:MANT_W]}) + BIAS_S;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign dz        = dz_q;

    // State and datapath registers; reset aborts any division in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            mb_q    <= '0;
            e_q     <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mb_q    <= mb_d;
            e_q     <= e_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic: accept, restoring-divide step, normalise/pack, handshake.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mb_d    = mb_q;
        e_d     = e_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        diff    = '0;
        en      = '0;
        mant    = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    mb_d   = {1'b1, b[MANT_W-1:0]};
                    e_d    = e_in;
                    rem_d  = {1'b0, 1'b1, a[MANT_W-1:0]};
                    q_d    = '0;
                    cnt_d  = CW'(QW - 1);
                    dz_d   = 1'b0;
                    if (b_zero) begin
                        // x/0 and 0/0 both report signed infinity with dz
                        res_d   = {sign_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (a_zero) begin
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    q_d[cnt_q] = 1'b1;
                    diff       = rem_q - {1'b0, mb_q};
                end else begin
                    diff = rem_q;
                end
                // diff < mB, so the shifted remainder always fits
                rem_d = {diff[QW-2:0], 1'b0};
                if (cnt_q == '0) state_d = S_NORM;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_NORM: begin
                // quotient lies in (0.5, 2): at most one left shift needed
                if (q_q[QW-1]) begin
                    mant = q_q[QW-2:1];
                    en   = e_q;
                end else begin
                    mant = q_q[QW-3:0];
                    en   = e_q - 1'b1;
                end
                if (en <= ZERO_S)      res_d = {sign_q, {(W-1){1'b0}}};
                else if (en >= EMAX_S) res_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                else                   res_d = {sign_q, en[EXP_W-1:0], mant};
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed-vector bench for fp32_divider_seq: table of results/latencies plus
// hand-written backpressure and mid-division reset sequences.
module tb_fp32_divider_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        dz;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    fp32_divider_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one operation, wait for out_valid (bounded), return result and
    // number of clock edges between the accept edge and out_valid visible.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic d, output int lat);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res; d = dz;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r, r0;
        logic        d;
        int          lat;
        bit          seen;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26};
        vecs[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 26};
        vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 0};
        vecs[4] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 1'b1, 0};
        vecs[5] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 0};
        vecs[6] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26};
        vecs[7] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset res",       res,                32'h0);
        chk("reset dz",        {31'b0, dz},        32'd0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, r, d, lat);
            chk($sformatf("vec%0d res", i), r, vecs[i].res);
            chk($sformatf("vec%0d dz", i), {31'b0, d}, {31'b0, vecs[i].dz});
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            handshake();
            chk($sformatf("vec%0d in_ready after hs", i), {31'b0, in_ready}, 32'd1);
        end

        // Backpressure: hold DONE for 5 cycles with a competing request.
        start_op(32'h40C00000, 32'h40000000, r0, d, lat);
        chk("bp first res", r0, 32'h40400000);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d res stable", k), res, 32'h40400000);
            chk($sformatf("bp%0d in_ready", k), {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp out_valid after hs", {31'b0, out_valid}, 32'd0);
        chk("bp in_ready after hs",  {31'b0, in_ready},  32'd1);

        // Reset during DIVIDE: no output, idle immediately, next op clean.
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-abort in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst-abort out_valid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst-abort no output", {31'b0, seen}, 32'd0);
        start_op(32'h40C00000, 32'h40000000, r, d, lat);
        chk("post-reset res", r, 32'h40400000);
        chk("post-reset latency", lat, 26);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
